// File: rtl/pll_sequencer_if.sv
// Signal bundle between the PLL start-up sequencer and its surroundings
// (PLL pins plus the control/status lines seen by the rest of the system).
interface pll_sequencer_if;
    // enable is a level; relock_req is a one-cycle pulse sampled on hwclk;
    // pll_lock is asynchronous. All sequencer outputs change only on hwclk.
    logic       enable;
    logic       relock_req;
    logic       pll_lock;
    logic       pll_resetb;
    logic       pll_bypass;
    logic       clk_ready;
    logic       lost_lock;
    logic       fault;
    logic [3:0] retries;
    logic [2:0] state;

    modport master (
        input  enable, relock_req, pll_lock,
        output pll_resetb, pll_bypass, clk_ready, lost_lock, fault, retries, state
    );

    modport slave (
        output enable, relock_req, pll_lock,
        input  pll_resetb, pll_bypass, clk_ready, lost_lock, fault, retries, state
    );
endinterface

// File: rtl/pll_sequencer.sv
// Start-up / supervision controller for the fast-clock PLL, clocked by the 12 MHz hwclk.
// Holds the PLL in reset, waits for a debounced lock, retries on timeout, re-sequences on lock loss.
module pll_sequencer #(
    parameter int RESET_CYCLES   = 12,
    parameter int LOCK_TIMEOUT   = 1200,
    parameter int LOCK_STABLE    = 64,
    parameter int MAX_RETRIES    = 3,
    parameter int BYPASS_ON_FAIL = 1
) (
    input  logic            hwclk,
    input  logic            resetb,
    pll_sequencer_if.master bus
);

    localparam int RW  = $clog2(RESET_CYCLES + 1);
    localparam int TW  = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW  = $clog2(LOCK_STABLE + 1);

    localparam logic [RW-1:0] RST_LAST = RW'(RESET_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] ST_DONE  = SW'(LOCK_STABLE);
    localparam logic [SW-1:0] ST_ONE   = SW'(1);
    localparam logic [3:0]    MAX_R    = 4'(MAX_RETRIES);
    localparam logic          BYP_FAIL = (BYPASS_ON_FAIL != 0);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESET     = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_STABLE    = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rst_cnt_q, rst_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [SW-1:0] stab_cnt_q, stab_cnt_d;
    logic [3:0]    retries_q, retries_d;
    logic          lost_lock_q, lost_lock_d;
    logic          pll_resetb_q, pll_bypass_q, clk_ready_q, fault_q;
    logic          lock_meta, lock_s;

    // Next state plus retry bookkeeping; enable=0 overrides every other transition.
    always_comb begin
        state_d     = state_q;
        retries_d   = retries_q;
        lost_lock_d = 1'b0;
        if (!bus.enable) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d   = S_RESET;
                    retries_d = '0;
                end
                S_RESET: begin
                    if (rst_cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = S_STABLE;
                    end else if (to_cnt_q == TO_LAST) begin
                        retries_d = retries_q + 4'd1;
                        state_d   = (retries_d == MAX_R) ? S_FAULT : S_RESET;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_d = S_WAIT_LOCK;
                    end else if (stab_cnt_q == ST_DONE) begin
                        state_d   = S_RUN;
                        retries_d = '0;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_d     = S_RESET;
                        lost_lock_d = 1'b1;
                    end else if (bus.relock_req) begin
                        state_d = S_RESET;
                    end
                end
                S_FAULT: begin
                    if (bus.relock_req) begin
                        state_d   = S_RESET;
                        retries_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Counters restart on every state entry, so none of them can wrap.
        rst_cnt_d  = (state_q == S_RESET && state_d == S_RESET) ? rst_cnt_q + 1'b1 : '0;
        to_cnt_d   = (state_q == S_WAIT_LOCK && state_d == S_WAIT_LOCK) ? to_cnt_q + 1'b1 : '0;
        if (state_d != S_STABLE)
            stab_cnt_d = '0;
        else if (state_q == S_STABLE)
            stab_cnt_d = stab_cnt_q + 1'b1;
        else
            stab_cnt_d = ST_ONE;
    end

    always_ff @(posedge hwclk) begin
        if (!resetb) begin
            state_q      <= S_IDLE;
            rst_cnt_q    <= '0;
            to_cnt_q     <= '0;
            stab_cnt_q   <= '0;
            retries_q    <= '0;
            lost_lock_q  <= 1'b0;
            pll_resetb_q <= 1'b0;
            pll_bypass_q <= 1'b0;
            clk_ready_q  <= 1'b0;
            fault_q      <= 1'b0;
            lock_meta    <= 1'b0;
            lock_s       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            to_cnt_q     <= to_cnt_d;
            stab_cnt_q   <= stab_cnt_d;
            retries_q    <= retries_d;
            lost_lock_q  <= lost_lock_d;
            // Outputs are decoded from the next state so they line up with the state register.
            pll_resetb_q <= (state_d == S_WAIT_LOCK) || (state_d == S_STABLE) || (state_d == S_RUN);
            pll_bypass_q <= (state_d == S_FAULT) && BYP_FAIL;
            clk_ready_q  <= (state_d == S_RUN);
            fault_q      <= (state_d == S_FAULT);
            lock_meta    <= bus.pll_lock;
            lock_s       <= lock_meta;
        end
    end

    assign bus.pll_resetb = pll_resetb_q;
    assign bus.pll_bypass = pll_bypass_q;
    assign bus.clk_ready  = clk_ready_q;
    assign bus.lost_lock  = lost_lock_q;
    assign bus.fault      = fault_q;
    assign bus.retries    = retries_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_pll_sequencer.sv
// Directed bench for pll_sequencer with shortened timing parameters;
// expected cycle numbers are hand-derived from the sequencing rules.
module tb_pll_sequencer;

    logic hwclk  = 1'b0;
    logic resetb = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    pll_sequencer_if bus ();

    pll_sequencer #(
        .RESET_CYCLES  (4),
        .LOCK_TIMEOUT  (20),
        .LOCK_STABLE   (8),
        .MAX_RETRIES   (2),
        .BYPASS_ON_FAIL(1)
    ) dut (
        .hwclk (hwclk),
        .resetb(resetb),
        .bus   (bus)
    );

    always #5 hwclk = ~hwclk;

    // One step = one rising edge; inputs are driven and outputs sampled 1 ns later.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge hwclk);
            #1;
        end
    endtask

    task automatic go_idle();
        bus.enable     = 1'b0;
        bus.relock_req = 1'b0;
        bus.pll_lock   = 1'b0;
        tick(4);
    endtask

    task automatic test_reset();
        bus.enable     = 1'b0;
        bus.relock_req = 1'b0;
        bus.pll_lock   = 1'b0;
        resetb         = 1'b0;
        tick(3);
        vectors++; if (bus.state !== 3'd0) begin miscompares++; $display("FAIL reset state: got %0d expected 0", bus.state); end
        vectors++; if (bus.pll_resetb !== 1'b0) begin miscompares++; $display("FAIL reset pll_resetb: got %b expected 0", bus.pll_resetb); end
        vectors++; if (bus.pll_bypass !== 1'b0) begin miscompares++; $display("FAIL reset pll_bypass: got %b expected 0", bus.pll_bypass); end
        vectors++; if (bus.clk_ready !== 1'b0) begin miscompares++; $display("FAIL reset clk_ready: got %b expected 0", bus.clk_ready); end
        vectors++; if (bus.lost_lock !== 1'b0) begin miscompares++; $display("FAIL reset lost_lock: got %b expected 0", bus.lost_lock); end
        vectors++; if (bus.fault !== 1'b0) begin miscompares++; $display("FAIL reset fault: got %b expected 0", bus.fault); end
        vectors++; if (bus.retries !== 4'd0) begin miscompares++; $display("FAIL reset retries: got %0d expected 0", bus.retries); end
        resetb = 1'b1;
        tick(2);
    endtask

    // Caller leaves the DUT in IDLE with lock low; the current cycle is cycle 0.
    task automatic bringup_sequence(input string tag);
        logic [2:0] exp_state;
        logic       exp_b;
        bus.enable = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            tick(1);
            exp_state = (c <= 4) ? 3'd1 : (c <= 12) ? 3'd2 : (c <= 20) ? 3'd3 : 3'd4;
            vectors++;
            if (bus.state !== exp_state) begin
                miscompares++;
                $display("FAIL %s state c%0d: got %0d expected %0d", tag, c, bus.state, exp_state);
            end
            exp_b = (c >= 5);
            vectors++;
            if (bus.pll_resetb !== exp_b) begin
                miscompares++;
                $display("FAIL %s pll_resetb c%0d: got %b expected %b", tag, c, bus.pll_resetb, exp_b);
            end
            exp_b = (c >= 21);
            vectors++;
            if (bus.clk_ready !== exp_b) begin
                miscompares++;
                $display("FAIL %s clk_ready c%0d: got %b expected %b", tag, c, bus.clk_ready, exp_b);
            end
            if (c == 10) bus.pll_lock = 1'b1;
        end
        vectors++; if (bus.retries !== 4'd0) begin miscompares++; $display("FAIL %s retries: got %0d expected 0", tag, bus.retries); end
        vectors++; if (bus.pll_bypass !== 1'b0) begin miscompares++; $display("FAIL %s pll_bypass: got %b expected 0", tag, bus.pll_bypass); end
    endtask

    task automatic test_bringup();
        go_idle();
        bringup_sequence("bringup");
    endtask

    task automatic test_timeout_fault();
        logic [2:0] exp_state;
        logic [3:0] exp_r;
        go_idle();
        bus.enable = 1'b1;
        for (int c = 1; c <= 52; c++) begin
            tick(1);
            exp_state = (c <= 4) ? 3'd1 : (c <= 24) ? 3'd2 : (c <= 28) ? 3'd1 : (c <= 48) ? 3'd2 : 3'd5;
            exp_r     = (c <= 24) ? 4'd0 : (c <= 48) ? 4'd1 : 4'd2;
            vectors++;
            if (bus.state !== exp_state) begin
                miscompares++;
                $display("FAIL timeout state c%0d: got %0d expected %0d", c, bus.state, exp_state);
            end
            vectors++;
            if (bus.retries !== exp_r) begin
                miscompares++;
                $display("FAIL timeout retries c%0d: got %0d expected %0d", c, bus.retries, exp_r);
            end
        end
        vectors++; if (bus.fault !== 1'b1) begin miscompares++; $display("FAIL fault flag: got %b expected 1", bus.fault); end
        vectors++; if (bus.pll_bypass !== 1'b1) begin miscompares++; $display("FAIL fault bypass: got %b expected 1", bus.pll_bypass); end
        vectors++; if (bus.pll_resetb !== 1'b0) begin miscompares++; $display("FAIL fault pll_resetb: got %b expected 0", bus.pll_resetb); end
        vectors++; if (bus.clk_ready !== 1'b0) begin miscompares++; $display("FAIL fault clk_ready: got %b expected 0", bus.clk_ready); end
        bus.relock_req = 1'b1;
        tick(1);
        bus.relock_req = 1'b0;
        vectors++; if (bus.state !== 3'd1) begin miscompares++; $display("FAIL relock state: got %0d expected 1", bus.state); end
        vectors++; if (bus.fault !== 1'b0) begin miscompares++; $display("FAIL relock fault: got %b expected 0", bus.fault); end
        vectors++; if (bus.retries !== 4'd0) begin miscompares++; $display("FAIL relock retries: got %0d expected 0", bus.retries); end
        vectors++; if (bus.pll_bypass !== 1'b0) begin miscompares++; $display("FAIL relock bypass: got %b expected 0", bus.pll_bypass); end
    endtask

    task automatic test_lock_glitch();
        logic [2:0] exp_state;
        logic       exp_b;
        go_idle();
        bus.enable = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            tick(1);
            exp_state = (c <= 4) ? 3'd1 : (c <= 12) ? 3'd2 : (c <= 17) ? 3'd3 :
                        (c == 18) ? 3'd2 : (c <= 26) ? 3'd3 : 3'd4;
            vectors++;
            if (bus.state !== exp_state) begin
                miscompares++;
                $display("FAIL glitch state c%0d: got %0d expected %0d", c, bus.state, exp_state);
            end
            exp_b = (c >= 27);
            vectors++;
            if (bus.clk_ready !== exp_b) begin
                miscompares++;
                $display("FAIL glitch clk_ready c%0d: got %b expected %b", c, bus.clk_ready, exp_b);
            end
            if (c == 10) bus.pll_lock = 1'b1;
            if (c == 15) bus.pll_lock = 1'b0;
            if (c == 16) bus.pll_lock = 1'b1;
        end
        vectors++; if (bus.retries !== 4'd0) begin miscompares++; $display("FAIL glitch retries: got %0d expected 0", bus.retries); end
    endtask

    task automatic test_loss_of_lock();
        logic [2:0] exp_state;
        logic       exp_b;
        go_idle();
        bus.enable   = 1'b1;
        bus.pll_lock = 1'b1;
        tick(14);
        vectors++; if (bus.state !== 3'd4) begin miscompares++; $display("FAIL loss pre-run state: got %0d expected 4", bus.state); end
        bus.pll_lock = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            exp_state = (k <= 2) ? 3'd4 : (k <= 6) ? 3'd1 : (k == 7) ? 3'd2 : (k <= 15) ? 3'd3 : 3'd4;
            vectors++;
            if (bus.state !== exp_state) begin
                miscompares++;
                $display("FAIL loss state k%0d: got %0d expected %0d", k, bus.state, exp_state);
            end
            exp_b = (k == 3);
            vectors++;
            if (bus.lost_lock !== exp_b) begin
                miscompares++;
                $display("FAIL loss lost_lock k%0d: got %b expected %b", k, bus.lost_lock, exp_b);
            end
            exp_b = (k <= 2) || (k == 16);
            vectors++;
            if (bus.clk_ready !== exp_b) begin
                miscompares++;
                $display("FAIL loss clk_ready k%0d: got %b expected %b", k, bus.clk_ready, exp_b);
            end
            if (k == 3) bus.pll_lock = 1'b1;
        end
        bus.relock_req = 1'b1;
        tick(1);
        bus.relock_req = 1'b0;
        vectors++; if (bus.state !== 3'd1) begin miscompares++; $display("FAIL run relock state: got %0d expected 1", bus.state); end
        vectors++; if (bus.lost_lock !== 1'b0) begin miscompares++; $display("FAIL run relock lost_lock: got %b expected 0", bus.lost_lock); end
        vectors++; if (bus.clk_ready !== 1'b0) begin miscompares++; $display("FAIL run relock clk_ready: got %b expected 0", bus.clk_ready); end
    endtask

    task automatic test_priority();
        go_idle();
        bus.enable   = 1'b1;
        bus.pll_lock = 1'b1;
        tick(14);
        vectors++; if (bus.state !== 3'd4) begin miscompares++; $display("FAIL prio pre-run state: got %0d expected 4", bus.state); end
        bus.enable     = 1'b0;
        bus.relock_req = 1'b1;
        tick(1);
        bus.relock_req = 1'b0;
        vectors++; if (bus.state !== 3'd0) begin miscompares++; $display("FAIL prio run state: got %0d expected 0", bus.state); end
        vectors++; if (bus.lost_lock !== 1'b0) begin miscompares++; $display("FAIL prio lost_lock: got %b expected 0", bus.lost_lock); end
        vectors++; if (bus.clk_ready !== 1'b0) begin miscompares++; $display("FAIL prio clk_ready: got %b expected 0", bus.clk_ready); end
        go_idle();
        bus.enable = 1'b1;
        tick(49);
        vectors++; if (bus.state !== 3'd5) begin miscompares++; $display("FAIL prio fault entry: got %0d expected 5", bus.state); end
        bus.enable = 1'b0;
        tick(1);
        vectors++; if (bus.state !== 3'd0) begin miscompares++; $display("FAIL prio fault exit state: got %0d expected 0", bus.state); end
        vectors++; if (bus.fault !== 1'b0) begin miscompares++; $display("FAIL prio fault flag: got %b expected 0", bus.fault); end
        vectors++; if (bus.pll_bypass !== 1'b0) begin miscompares++; $display("FAIL prio bypass: got %b expected 0", bus.pll_bypass); end
    endtask

    task automatic test_reset_midop();
        go_idle();
        bus.enable = 1'b1;
        tick(7);
        vectors++; if (bus.state !== 3'd2) begin miscompares++; $display("FAIL midop wait state: got %0d expected 2", bus.state); end
        resetb = 1'b0;
        tick(1);
        resetb = 1'b1;
        vectors++; if (bus.state !== 3'd0) begin miscompares++; $display("FAIL midop wait reset state: got %0d expected 0", bus.state); end
        vectors++; if (bus.pll_resetb !== 1'b0) begin miscompares++; $display("FAIL midop wait pll_resetb: got %b expected 0", bus.pll_resetb); end
        bringup_sequence("restart_wait");
        bus.pll_lock = 1'b0;
        resetb       = 1'b0;
        tick(1);
        resetb = 1'b1;
        vectors++; if (bus.state !== 3'd0) begin miscompares++; $display("FAIL midop run reset state: got %0d expected 0", bus.state); end
        vectors++; if (bus.pll_resetb !== 1'b0) begin miscompares++; $display("FAIL midop run pll_resetb: got %b expected 0", bus.pll_resetb); end
        vectors++; if (bus.clk_ready !== 1'b0) begin miscompares++; $display("FAIL midop run clk_ready: got %b expected 0", bus.clk_ready); end
        vectors++; if (bus.lost_lock !== 1'b0) begin miscompares++; $display("FAIL midop run lost_lock: got %b expected 0", bus.lost_lock); end
        bringup_sequence("restart_run");
    endtask

    initial begin
        bus.enable     = 1'b0;
        bus.relock_req = 1'b0;
        bus.pll_lock   = 1'b0;
        test_reset();
        test_bringup();
        test_timeout_fault();
        test_lock_glitch();
        test_loss_of_lock();
        test_priority();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
